// File: rtl/ram_sp_initclr.sv
// rtl/ram_sp_initclr.sv - single-port RAM with valid/ready requests, registered read response and hardware clear FSM
// Optional per-word even parity with error reporting is enabled by defining RAM_PARITY_EN.
module ram_sp_initclr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              init_busy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef RAM_PARITY_EN
    ,
    output logic              rsp_perr,
    input  logic              perr_inject
`endif
);

`ifdef RAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_V  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
`ifdef RAM_PARITY_EN
    logic              rsp_perr_q, rsp_perr_d;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [MEM_W-1:0]  mem_wword;

    logic              accept;
    logic              addr_ok;
    logic [IDX_W-1:0]  req_idx;
    logic [MEM_W-1:0]  rd_word;

    // Range check is done one bit wider so DEPTH == 2**ADDR_W still compares correctly.
    assign addr_ok   = ({1'b0, req_addr} < DEPTH_V);
    assign req_idx   = req_addr[IDX_W-1:0];
    assign rd_word   = mem[req_idx];

    assign init_busy = (state_q == ST_CLEAR) || rst;
    assign req_ready = (state_q == ST_RUN) && !clr_req;
    assign accept    = req_valid && req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
`ifdef RAM_PARITY_EN
    assign rsp_perr  = rsp_perr_q;
`endif

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef RAM_PARITY_EN
        rsp_perr_d  = rsp_perr_q;
`endif
        mem_we      = 1'b0;
        mem_widx    = req_idx;
        mem_wword   = '0;

        case (state_q)
            ST_CLEAR: begin
                // All-zero word also carries parity 0, which is consistent even parity.
                mem_we   = 1'b1;
                mem_widx = clr_cnt_q[IDX_W-1:0];
                if (clr_cnt_q == LAST_V) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (accept) begin
                    if (req_we) begin
                        mem_we = addr_ok;
`ifdef RAM_PARITY_EN
                        mem_wword = {(^req_wdata) ^ perr_inject, req_wdata};
`else
                        mem_wword = req_wdata;
`endif
                    end else begin
                        rsp_valid_d = 1'b1;
                        if (addr_ok) begin
                            rsp_rdata_d = rd_word[DATA_W-1:0];
                            rsp_err_d   = 1'b0;
`ifdef RAM_PARITY_EN
                            rsp_perr_d  = rd_word[DATA_W] ^ (^rd_word[DATA_W-1:0]);
`endif
                        end else begin
                            rsp_rdata_d = '0;
                            rsp_err_d   = 1'b1;
`ifdef RAM_PARITY_EN
                            rsp_perr_d  = 1'b0;
`endif
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef RAM_PARITY_EN
            rsp_perr_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef RAM_PARITY_EN
            rsp_perr_q  <= rsp_perr_d;
`endif
        end
    end

    // Storage array has no reset; its contents are initialised only by the clear FSM.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_widx] <= mem_wword;
        end
    end

endmodule

// File: tb/tb_ram_sp_initclr.sv
// tb/tb_ram_sp_initclr.sv - self-checking bench for ram_sp_initclr (DEPTH 256 and DEPTH 200 instances)
module tb_ram_sp_initclr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_req = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;

    logic       a_init_busy, a_req_ready, a_rsp_valid, a_rsp_err;
    logic [7:0] a_rsp_rdata;
    logic       b_init_busy, b_req_ready, b_rsp_valid, b_rsp_err;
    logic [7:0] b_rsp_rdata;
`ifdef RAM_PARITY_EN
    logic       perr_inject = 1'b0;
    logic       a_rsp_perr, b_rsp_perr;
`endif

    always #5 clk = ~clk;

    ram_sp_initclr #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .init_busy(a_init_busy),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
`ifdef RAM_PARITY_EN
        , .rsp_perr(a_rsp_perr), .perr_inject(perr_inject)
`endif
    );

    ram_sp_initclr #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .init_busy(b_init_busy),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
`ifdef RAM_PARITY_EN
        , .rsp_perr(b_rsp_perr), .perr_inject(perr_inject)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain word arrays plus a per-word "parity corrupted" flag.
    logic [7:0] ma [256];
    logic [7:0] mb [200];
    logic       pa [256];
    logic       pb [200];
    logic [7:0] last_ra = 8'h00, last_rb = 8'h00;
    logic       last_ea = 1'b0, last_eb = 1'b0;
    logic       last_pa = 1'b0, last_pb = 1'b0;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_err_b;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            ma[i] = 8'h00;
            pa[i] = 1'b0;
        end
        for (int i = 0; i < 200; i++) begin
            mb[i] = 8'h00;
            pb[i] = 1'b0;
        end
    endtask

    // Counts busy cycles of both instances; optionally pulses clr_req mid-clear, which must be ignored.
    task automatic wait_clear(input string nm, input int pulse_at);
        int ca, cb;
        ca = 0;
        cb = 0;
        while (a_init_busy && ca < 1000) begin
            clr_req = (ca == pulse_at);
            ca++;
            if (b_init_busy) cb++;
            step();
        end
        clr_req = 1'b0;
        chk({nm, "_busy_a"}, ca, 256);
        chk({nm, "_busy_b"}, cb, 200);
        chk({nm, "_ready_a"}, a_req_ready, 1);
        chk({nm, "_ready_b"}, b_req_ready, 1);
        model_clear();
    endtask

    // One cycle of request (or idle when v=0), checked against the model on the following cycle.
    task automatic cycle_req(input string nm, input logic v, input logic we,
                             input logic [7:0] addr, input logic [7:0] wdata, input logic inj);
        int ai;
        logic rd;
        ai = addr;
        rd = v && !we;
        if (rd) begin
            last_ra = ma[ai];
            last_ea = 1'b0;
            last_pa = pa[ai];
            last_rb = (ai < 200) ? mb[ai] : 8'h00;
            last_eb = (ai >= 200);
            last_pb = (ai < 200) ? pb[ai] : 1'b0;
        end
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
`ifdef RAM_PARITY_EN
        perr_inject = inj;
`endif
        if (v) begin
            chk({nm, "_ready_a"}, a_req_ready, 1);
            chk({nm, "_ready_b"}, b_req_ready, 1);
        end
        step();
        req_valid = 1'b0;
`ifdef RAM_PARITY_EN
        perr_inject = 1'b0;
`endif
        if (v && we) begin
            ma[ai] = wdata;
            pa[ai] = inj;
            if (ai < 200) begin
                mb[ai] = wdata;
                pb[ai] = inj;
            end
        end
        chk({nm, "_valid_a"}, a_rsp_valid, rd);
        chk({nm, "_valid_b"}, b_rsp_valid, rd);
        chk({nm, "_rdata_a"}, a_rsp_rdata, last_ra);
        chk({nm, "_rdata_b"}, b_rsp_rdata, last_rb);
        chk({nm, "_err_a"}, a_rsp_err, last_ea);
        chk({nm, "_err_b"}, b_rsp_err, last_eb);
`ifdef RAM_PARITY_EN
        chk({nm, "_perr_a"}, a_rsp_perr, last_pa);
        chk({nm, "_perr_b"}, b_rsp_perr, last_pb);
`endif
    endtask

    initial begin
        vt[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 8'h00, 1'b0};
        vt[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 8'hA5, 1'b0};
        vt[2]  = '{1'b0, 8'h11, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[4]  = '{1'b0, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[5]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1};
        vt[6]  = '{1'b1, 8'hC8, 8'h55, 8'h00, 8'h00, 1'b0};
        vt[7]  = '{1'b0, 8'hC8, 8'h00, 8'h55, 8'h00, 1'b1};
        vt[8]  = '{1'b0, 8'hC7, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[9]  = '{1'b1, 8'h05, 8'h3C, 8'h00, 8'h00, 1'b0};
        vt[10] = '{1'b0, 8'h05, 8'h00, 8'h3C, 8'h3C, 1'b0};

        model_clear();

        // Reset state
        step();
        step();
        chk("rst_busy_a", a_init_busy, 1);
        chk("rst_ready_a", a_req_ready, 0);
        chk("rst_valid_a", a_rsp_valid, 0);
        chk("rst_rdata_a", a_rsp_rdata, 0);
        chk("rst_err_a", a_rsp_err, 0);
        chk("rst_busy_b", b_init_busy, 1);
        rst = 1'b0;
        wait_clear("init", -1);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            cycle_req($sformatf("vec%0d", i), 1'b1, vt[i].we, vt[i].addr, vt[i].wdata, 1'b0);
            if (!vt[i].we) begin
                chk($sformatf("vec%0d_tbl_a", i), a_rsp_rdata, vt[i].exp_a);
                chk($sformatf("vec%0d_tbl_b", i), b_rsp_rdata, vt[i].exp_b);
                chk($sformatf("vec%0d_tbl_eb", i), b_rsp_err, vt[i].exp_err_b);
            end
        end

        // clr_req wins over a same-cycle read; a second clr_req mid-clear is ignored
        clr_req   = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h05;
        #1;
        chk("clr_ready_a", a_req_ready, 0);
        chk("clr_ready_b", b_req_ready, 0);
        step();
        clr_req   = 1'b0;
        req_valid = 1'b0;
        chk("clr_novalid_a", a_rsp_valid, 0);
        chk("clr_novalid_b", b_rsp_valid, 0);
        wait_clear("clr", 50);
        cycle_req("reread05", 1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
        chk("reread05_zero", a_rsp_rdata, 0);

        // Reset at clear cycle 100 restarts the clear
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (99) step();
        chk("mid_busy_a", a_init_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_ra = 8'h00; last_rb = 8'h00; last_ea = 1'b0; last_eb = 1'b0;
        last_pa = 1'b0;  last_pb = 1'b0;
        wait_clear("rstclr", -1);

        // Reset kills a pending read response
        cycle_req("pre_rst_wr", 1'b1, 1'b1, 8'h10, 8'h77, 1'b0);
        cycle_req("pre_rst_rd", 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        rst       = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rstkill_valid_a", a_rsp_valid, 0);
        chk("rstkill_valid_b", b_rsp_valid, 0);
        chk("rstkill_rdata_a", a_rsp_rdata, 0);
        rst = 1'b0;
        last_ra = 8'h00; last_rb = 8'h00; last_ea = 1'b0; last_eb = 1'b0;
        last_pa = 1'b0;  last_pb = 1'b0;
        wait_clear("rstkill", -1);

`ifdef RAM_PARITY_EN
        cycle_req("par_wr_inj", 1'b1, 1'b1, 8'h20, 8'h01, 1'b1);
        cycle_req("par_rd_inj", 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        chk("par_inj_perr", a_rsp_perr, 1);
        chk("par_inj_rdata", a_rsp_rdata, 8'h01);
        cycle_req("par_wr_ok", 1'b1, 1'b1, 8'h20, 8'h01, 1'b0);
        cycle_req("par_rd_ok", 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        chk("par_ok_perr", a_rsp_perr, 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic       v, we, inj;
            logic [7:0] addr;
            v    = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1);
            inj  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       addr = 8'($urandom_range(192, 207));
                1:       addr = 8'($urandom_range(0, 15));
                default: addr = 8'($urandom_range(0, 255));
            endcase
            cycle_req("rand", v, we, addr, 8'($urandom), inj);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sp_initclr.md
Name: ram_sp_initclr

Overview:
- Parametrised single-port synchronous RAM with a valid/ready request port and a registered read-response port.
- Hardware clear FSM zeroes every word, one per cycle, after reset and on demand.
- Out-of-range addresses are flagged rather than aliased.
- Used as the generic scratch/buffer memory behind testbench-driven datapaths.

Parameters:
- DATA_W, 8, word width in bits (>=1).
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  one-cycle pulse; starts a full memory clear.
- init_busy  out  1  high while the clear FSM is running.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read response valid, one-cycle pulse.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  qualifies rsp_valid; 1 = address >= DEPTH.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- FSM states:
  - CLEAR: counter clr_cnt (width ADDR_W+1) writes 0 to mem[clr_cnt], then increments.
  - RUN: serves requests.
- Reset: state=CLEAR, clr_cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. init_busy=1 while rst is asserted.
- CLEAR -> RUN on the cycle clr_cnt==DEPTH-1 is written. Clearing takes exactly DEPTH cycles after rst deasserts.
- RUN -> CLEAR when clr_req=1; clr_cnt reloads 0. clr_req during CLEAR is ignored; the clear is not restarted.
- init_busy = (state==CLEAR), combinational from state.
- req_ready = (state==RUN) && !clr_req. clr_req wins over a same-cycle request; that request is not accepted and must be held by the requester.
- No backpressure on the response side. Single port: at most one access per cycle.
- Accepted write, addr < DEPTH: mem[addr] <= req_wdata. No response is generated.
- Accepted write, addr >= DEPTH: dropped silently; memory unchanged.
- Accepted read: rsp_valid=1 on the next cycle (latency 1).
  - addr < DEPTH: rsp_rdata = mem[addr], rsp_err=0.
  - addr >= DEPTH: rsp_rdata = 0, rsp_err=1.
- rsp_valid deasserts the cycle after unless another read is accepted.
- rsp_rdata and rsp_err hold their last values when rsp_valid=0.
- Back-to-back reads sustain one response per cycle.
- Write followed by read of the same address on the next cycle returns the new data.
- Reset mid-clear, or mid-read with a response pending: the pending rsp_valid is killed, and the clear restarts from address 0.
- Memory is never cleared combinationally and never in a multi-write loop; only the FSM clears it.

Optional Feature:
- Macro RAM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on write. Clear writes parity 0.
  - Output port rsp_perr (1 bit, reset 0) is added, aligned with rsp_valid. It is 1 when the stored parity mismatches the recomputed parity of the read word.
  - Input port perr_inject (1 bit) is added; when high on an accepted write, the stored parity bit is inverted.
  - rsp_perr is 0 for out-of-range reads.
- When undefined: no parity storage, and neither port exists.

Test Plan:
1. Deassert rst, poll init_busy -> init_busy=1 for exactly 256 cycles, req_ready rises on cycle 256; read addr 0x00, 0x7F and 0xFF -> rsp_rdata=0x00, rsp_err=0 each.
2. Write 0xA5 to addr 0x10, then read 0x10 on the next cycle -> rsp_valid exactly one cycle after acceptance, rsp_rdata=0xA5. Back-to-back reads of 0x10, 0x11 -> 0xA5, 0x00 on consecutive cycles.
3. DEPTH=200: write 0x55 to addr 0xC8, then read 0xC8 -> rsp_err=1, rsp_rdata=0x00; read 0xC7 -> 0x00, rsp_err=0.
4. Write 0x3C to addr 0x05, pulse clr_req together with req_valid -> req_ready=0 that cycle, init_busy=1 for 256 cycles; reissued read of 0x05 -> 0x00.
5. Assert rst for one cycle at clear cycle 100 -> clear restarts from 0, total busy 256 cycles after rst deasserts. Assert rst during a pending read -> rsp_valid=0 the next cycle.
6. RAM_PARITY_EN: write 0x01 with perr_inject=1 to addr 0x20, read it back -> rsp_rdata=0x01, rsp_perr=1. Write 0x01 without inject, read it back -> rsp_perr=0.
